// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, the reserved opcode, and the command word
// carried from the command FIFO into the issue register.
package alu_pkg;

    typedef enum logic [2:0] {
        AND = 3'b000,
        OR  = 3'b001,
        ADD = 3'b010,
        XOR = 3'b011,
        NOR = 3'b100,
        SUB = 3'b110,
        SLT = 3'b111
    } alu_op_e;

    // Encoding with no ALU function behind it.
    localparam logic [2:0] ALU_OP_ILLEGAL = 3'b101;

    // Widest tag the command struct can carry; narrower tags are zero-extended.
    localparam int ALU_TAG_MAX_W = 16;

    // op is kept as raw bits so the reserved encoding can be represented.
    typedef struct packed {
        logic [31:0]              a;
        logic [31:0]              b;
        logic [2:0]               op;
        logic [ALU_TAG_MAX_W-1:0] tag;
        logic                     err;
    } alu_cmd_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pointers are log2(DEPTH) bits and
// wrap naturally; push on full and pop on empty are ignored. Read data is
// zero while empty so downstream outputs stay quiet.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign full_o  = (cnt == (AW+1)'(DEPTH));
    assign empty_o = (cnt == '0);
    assign count_o = cnt;
    assign rdata_o = empty_o ? '0 : mem[rptr];

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata_i;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: command FIFO -> S1 (drives ALU) -> S2 (tracks ALU result)
// -> response FIFO. Issue is gated by credits so every issued op has a
// guaranteed response slot. Optional macro ALU_ISSUE_ILLEGAL_CHK_EN flags
// opcode 3'b101 and answers it with result=0, zero=1, err=1.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_a_i,
    input  logic [31:0]      cmd_b_i,
    input  logic [2:0]       cmd_op_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic             rsp_zero_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o
);
    localparam int CW  = 32 + 32 + 3 + TAG_W + 1;
    localparam int RW  = 32 + 1 + TAG_W + 1;
    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

    // ---------------- command side ----------------
    logic             cmd_err, cmd_push, cmd_full, cmd_empty;
    logic [CW-1:0]    cmd_wdata, cmd_rdata;
    logic [CCW-1:0]   cmd_count;
    logic [31:0]      cq_a, cq_b;
    logic [2:0]       cq_op;
    logic [TAG_W-1:0] cq_tag;
    logic             cq_err;

`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    assign cmd_err = (cmd_op_i == ALU_OP_ILLEGAL);
`else
    assign cmd_err = 1'b0;
`endif

    assign cmd_push    = cmd_valid_i & ~cmd_full;
    assign cmd_ready_o = ~cmd_full;
    assign cmd_wdata   = {cmd_a_i, cmd_b_i, cmd_op_i, cmd_tag_i, cmd_err};
    assign {cq_a, cq_b, cq_op, cq_tag, cq_err} = cmd_rdata;

    // ---------------- issue / credits ----------------
    alu_cmd_t         s1;
    logic [1:0]       vld_pipe;      // [0] = S1 valid, [1] = S2 valid
    logic [TAG_W-1:0] s2_tag;
    logic             s2_err;
    logic             issue, rsp_pop, rsp_full, rsp_empty;
    logic [RCW-1:0]   rsp_count;
    logic [RCW:0]     credits_used;

    // Slots already spoken for after this edge's response pop.
    assign rsp_pop      = rsp_valid_o & rsp_ready_i;
    assign credits_used = (RCW+1)'(rsp_count) + (RCW+1)'(vld_pipe[0])
                        + (RCW+1)'(vld_pipe[1]) - (RCW+1)'(rsp_pop);
    assign issue        = ~cmd_empty & (credits_used < (RCW+1)'(RSP_DEPTH));

    // S1 operand register; holds its last value when nothing issues. A flagged
    // op is neutralised to AND 0,0 so the ALU does harmless work in its slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= '0;
        end else if (issue) begin
            s1.a   <= cq_err ? 32'd0 : cq_a;
            s1.b   <= cq_err ? 32'd0 : cq_b;
            s1.op  <= cq_err ? 3'(AND) : cq_op;
            s1.tag <= ALU_TAG_MAX_W'(cq_tag);
            s1.err <= cq_err;
        end
    end

    // Valid shift and S2 tracking; S2 lines up with the ALU's registered result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], issue};
            s2_tag   <= s1.tag[TAG_W-1:0];
            s2_err   <= s1.err;
        end
    end

    assign alu_a_o  = s1.a;
    assign alu_b_o  = s1.b;
    assign alu_op_o = s1.op;

    // ---------------- response side ----------------
    logic [31:0]   cap_result;
    logic          cap_zero, rsp_err_rd;
    logic [RW-1:0] rsp_wdata, rsp_rdata;

    assign cap_result = s2_err ? 32'd0 : alu_result_i;
    assign cap_zero   = s2_err | alu_zero_i;
    assign rsp_wdata  = {cap_result, cap_zero, s2_tag, s2_err};
    assign rsp_valid_o = ~rsp_empty;
    assign {rsp_result_o, rsp_zero_o, rsp_tag_o, rsp_err_rd} = rsp_rdata;

`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    assign rsp_err_o = rsp_err_rd;
`else
    logic unused_rsp_err;
    assign unused_rsp_err = rsp_err_rd;
    assign rsp_err_o      = 1'b0;
`endif

    // Signals kept for visibility but not consumed here.
    logic unused_misc;
    assign unused_misc = ^{cmd_count, rsp_full, s1.tag};

    alu_sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_push),
        .wdata_i (cmd_wdata),
        .pop_i   (issue),
        .rdata_o (cmd_rdata),
        .count_o (cmd_count),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    // Credits guarantee this push never meets a full FIFO.
    alu_sync_fifo #(.WIDTH(RW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (vld_pipe[1]),
        .wdata_i (rsp_wdata),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_rdata),
        .count_o (rsp_count),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural registered ALU, expected responses
// queued at command time and popped on each response handshake.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [31:0]      cmd_a_i = '0;
    logic [31:0]      cmd_b_i = '0;
    logic [2:0]       cmd_op_i = '0;
    logic [TAG_W-1:0] cmd_tag_i = '0;
    logic [31:0]      alu_a_o, alu_b_o;
    logic [2:0]       alu_op_o;
    logic [31:0]      alu_result_i = '0;
    logic             alu_zero_i = 1'b0;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [31:0]      rsp_result_o;
    logic             rsp_zero_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             rsp_err_o;

    typedef struct packed {
        logic [31:0]      r;
        logic             z;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   nrsp = 0;
    bit   rnd_rdy = 1'b0;

    alu_issue_stage #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i), .cmd_tag_i(cmd_tag_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
        .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a | b);
            3'b110:  return a - b;
            3'b111:  return {31'd0, $signed(a) < $signed(b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Registered ALU stand-in.
    always @(posedge clk_i) begin
        alu_result_i <= alu_ref(alu_a_o, alu_b_o, alu_op_o);
        alu_zero_i   <= (alu_ref(alu_a_o, alu_b_o, alu_op_o) == 32'd0);
    end

    function automatic exp_t mk_exp(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.r   = alu_ref(a, b, op);
        e.z   = (e.r == 32'd0);
        e.tag = tag;
        e.err = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
        if (op == ALU_OP_ILLEGAL) begin
            e.r = 32'd0; e.z = 1'b1; e.err = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int n;
        cmd_valid_i = 1'b1;
        cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_tag_i = tag;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) chk("send_timeout", 64'(cmd_ready_o), 64'd1);
        else sb.push_back(mk_exp(op, a, b, tag));
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n0;
        fork
            // Response monitor: compare on every handshake.
            begin
                exp_t e;
                forever begin
                    @(negedge clk_i);
                    #2;
                    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
                        if (sb.size() == 0) begin
                            chk("rsp_spurious", 64'(rsp_valid_o), 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_result", 64'(rsp_result_o), 64'(e.r));
                            chk("rsp_zero",   64'(rsp_zero_o),   64'(e.z));
                            chk("rsp_tag",    64'(rsp_tag_o),    64'(e.tag));
                            chk("rsp_err",    64'(rsp_err_o),    64'(e.err));
                            nrsp++;
                        end
                    end
                end
            end
            // Random response backpressure.
            forever begin
                @(posedge clk_i);
                #1;
                if (rnd_rdy) rsp_ready_i = 1'($urandom_range(0, 1));
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_alu_a",     64'(alu_a_o),      64'd0);
        chk("rst_alu_b",     64'(alu_b_o),      64'd0);
        chk("rst_alu_op",    64'(alu_op_o),     64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o),  64'd0);
        chk("rst_rsp_res",   64'(rsp_result_o), 64'd0);
        chk("rst_rsp_tag",   64'(rsp_tag_o),    64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);

        // 1: single op latency
        rsp_ready_i = 1'b1;
        send(ADD, 32'd5, 32'd7, 4'd3);
        @(negedge clk_i);
        chk("t1_alu_a",   64'(alu_a_o),     64'd5);
        chk("t1_alu_b",   64'(alu_b_o),     64'd7);
        chk("t1_alu_op",  64'(alu_op_o),    64'(ADD));
        chk("t1_valid_e1", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        chk("t1_valid_e2", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        chk("t1_valid_e3", 64'(rsp_valid_o), 64'd1);
        drain("t1_drain");

        // 2: back-to-back, one response per cycle
        send(SUB, 32'd9, 32'd9, 4'd1);
        send(SLT, 32'd1, 32'd2, 4'd2);
        send(NOR, 32'd0, 32'd0, 4'd3);
        send(XOR, 32'hFFFF_0000, 32'hFFFF_FFFF, 4'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_b2b_valid", 64'(rsp_valid_o), 64'd1);
            @(negedge clk_i);
        end
        drain("t2_drain");

        // 3: backpressure fills both FIFOs
        rsp_ready_i = 1'b0;
        n0 = nrsp;
        for (int i = 0; i < 8; i++) send(ADD, 32'(i), 32'd100, 4'(i));
        repeat (4) @(negedge clk_i);
        chk("t3_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("t3_rsp_valid", 64'(rsp_valid_o), 64'd1);
        rsp_ready_i = 1'b1;
        drain("t3_drain");
        chk("t3_count", 64'(nrsp - n0), 64'd8);

        // 4: reset mid-stream
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(OR, 32'(i + 10), 32'd1, 4'(i + 8));
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk("t4_alu_a",     64'(alu_a_o),     64'd0);
        chk("t4_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("t4_cmd_ready", 64'(cmd_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("t4_no_stale", 64'(rsp_valid_o), 64'd0);
        n0 = nrsp;
        send(ADD, 32'd1, 32'd1, 4'd5);
        drain("t4_drain");
        chk("t4_count", 64'(nrsp - n0), 64'd1);

        // 5: wrap with random ready gaps
        n0 = nrsp;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 12; i++)
            send(3'($urandom_range(0, 7)), $urandom, $urandom, 4'(i));
        rnd_rdy = 1'b0;
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        drain("t5_drain");
        chk("t5_count", 64'(nrsp - n0), 64'd12);

        // 6: reserved opcode then a normal op
        send(ALU_OP_ILLEGAL, 32'd3, 32'd4, 4'd9);
        send(ADD, 32'd2, 32'd2, 4'd10);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
